// File: rtl/control_step_sequencer.sv
// T-step timing generator for the CPU control unit: one-hot control steps with
// variable-length instructions, memory-wait stalls, single-step and stop/start.
module control_step_sequencer #(
    parameter int MAX_STEPS = 8,
    parameter int STEP_W    = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stop,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step_go,
    input  logic                 wait_req,
    input  logic                 last_step,
    output logic [MAX_STEPS-1:0] t_onehot,
    output logic [STEP_W-1:0]    t_index,
    output logic                 run,
    output logic                 instr_done,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 step_err
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [MAX_STEPS-1:0] ONEHOT_T0 = {{(MAX_STEPS-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0]    LAST_IDX  = STEP_W'(MAX_STEPS - 1);

    state_t               state_q, state_d;
    logic [STEP_W-1:0]    t_index_q, t_index_d;
    logic [MAX_STEPS-1:0] t_onehot_q, t_onehot_d;
    logic                 run_q, run_d;
    logic                 instr_done_q, instr_done_d;
    logic [CNT_W-1:0]     instr_count_q, instr_count_d;
    logic                 step_err_q, step_err_d;
    logic                 stop_pending_q, stop_pending_d;

    logic adv_s;
    logic at_max_s;
    logic end_s;

    // Step qualifiers: a stall always beats a step enable or an end marker.
    always_comb begin
        adv_s    = !wait_req && (!step_mode || step_go);
        at_max_s = (t_index_q == LAST_IDX);
        end_s    = last_step || at_max_s;
    end

    // Next-state and next-output computation for the INIT/RUN/HALT machine.
    always_comb begin
        state_d        = state_q;
        t_index_d      = t_index_q;
        t_onehot_d     = t_onehot_q;
        run_d          = run_q;
        instr_done_d   = 1'b0;
        instr_count_d  = instr_count_q;
        step_err_d     = step_err_q;
        stop_pending_d = stop_pending_q;
        case (state_q)
            ST_INIT: begin
                state_d    = ST_RUN;
                t_index_d  = {STEP_W{1'b0}};
                t_onehot_d = ONEHOT_T0;
                run_d      = 1'b1;
            end
            ST_RUN: begin
                if (adv_s && at_max_s && !last_step) begin
                    step_err_d = 1'b1;
                end else begin
                    step_err_d = step_err_q;
                end
                if (adv_s && end_s) begin
                    instr_count_d  = instr_count_q + CNT_W'(1);
                    instr_done_d   = 1'b1;
                    t_index_d      = {STEP_W{1'b0}};
                    stop_pending_d = 1'b0;
                    // A stop seen on this very edge still halts at this boundary.
                    if (stop_pending_q || stop) begin
                        state_d    = ST_HALT;
                        t_onehot_d = {MAX_STEPS{1'b0}};
                        run_d      = 1'b0;
                    end else begin
                        state_d    = ST_RUN;
                        t_onehot_d = ONEHOT_T0;
                        run_d      = 1'b1;
                    end
                end else if (adv_s) begin
                    t_index_d      = t_index_q + STEP_W'(1);
                    t_onehot_d     = t_onehot_q << 1;
                    stop_pending_d = stop_pending_q || stop;
                end else begin
                    stop_pending_d = stop_pending_q || stop;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d    = ST_RUN;
                    t_index_d  = {STEP_W{1'b0}};
                    t_onehot_d = ONEHOT_T0;
                    run_d      = 1'b1;
                end else begin
                    state_d    = ST_HALT;
                    t_index_d  = {STEP_W{1'b0}};
                    t_onehot_d = {MAX_STEPS{1'b0}};
                    run_d      = 1'b0;
                end
            end
            default: begin
                state_d        = ST_INIT;
                t_index_d      = {STEP_W{1'b0}};
                t_onehot_d     = {MAX_STEPS{1'b0}};
                run_d          = 1'b0;
                stop_pending_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_INIT;
            t_index_q      <= {STEP_W{1'b0}};
            t_onehot_q     <= {MAX_STEPS{1'b0}};
            run_q          <= 1'b0;
            instr_done_q   <= 1'b0;
            instr_count_q  <= {CNT_W{1'b0}};
            step_err_q     <= 1'b0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            t_index_q      <= t_index_d;
            t_onehot_q     <= t_onehot_d;
            run_q          <= run_d;
            instr_done_q   <= instr_done_d;
            instr_count_q  <= instr_count_d;
            step_err_q     <= step_err_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    assign t_onehot    = t_onehot_q;
    assign t_index     = t_index_q;
    assign run         = run_q;
    assign instr_done  = instr_done_q;
    assign instr_count = instr_count_q;
    assign step_err    = step_err_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed bench for control_step_sequencer: step sequencing, stalls, stop/start,
// single-step, forced wrap with error, async reset and counter wrap (CNT_W=4).
module tb_control_step_sequencer;

    localparam int MAX_STEPS = 8;
    localparam int STEP_W    = 3;
    localparam int CNT_W     = 4;

    logic                 clock;
    logic                 reset;
    logic                 stop;
    logic                 start;
    logic                 step_mode;
    logic                 step_go;
    logic                 wait_req;
    logic                 last_step;
    logic [MAX_STEPS-1:0] t_onehot;
    logic [STEP_W-1:0]    t_index;
    logic                 run;
    logic                 instr_done;
    logic [CNT_W-1:0]     instr_count;
    logic                 step_err;

    int vectors_applied;
    int miscompares;

    control_step_sequencer #(
        .MAX_STEPS(MAX_STEPS),
        .STEP_W   (STEP_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stop       (stop),
        .start      (start),
        .step_mode  (step_mode),
        .step_go    (step_go),
        .wait_req   (wait_req),
        .last_step  (last_step),
        .t_onehot   (t_onehot),
        .t_index    (t_index),
        .run        (run),
        .instr_done (instr_done),
        .instr_count(instr_count),
        .step_err   (step_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks a RUN-state step: index, one-hot pattern and run flag.
    task automatic check_step(input string tag, input int idx);
        logic [31:0] exp_oh;
        exp_oh = 32'd1 << idx;
        check_val({tag, ".idx"}, 32'(t_index), 32'(idx));
        check_val({tag, ".oh"}, 32'(t_onehot), exp_oh);
        check_val({tag, ".run"}, 32'(run), 32'd1);
    endtask

    task automatic check_halt(input string tag);
        check_val({tag, ".idx"}, 32'(t_index), 32'd0);
        check_val({tag, ".oh"}, 32'(t_onehot), 32'd0);
        check_val({tag, ".run"}, 32'(run), 32'd0);
    endtask

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        reset     = 1'b0;
        stop      = 1'b0;
        start     = 1'b0;
        step_mode = 1'b0;
        step_go   = 1'b0;
        wait_req  = 1'b0;
        last_step = 1'b0;
        #1;
        check_halt("rst");
        check_val("rst.cnt", 32'(instr_count), 32'd0);
        check_val("rst.done", 32'(instr_done), 32'd0);
        check_val("rst.err", 32'(step_err), 32'd0);
        #1 reset = 1'b1;

        // INIT -> RUN at T0, then a 4-step instruction
        tick(); check_step("init", 0);
        tick(); check_step("t1", 1);
        tick(); check_step("t2", 2);
        tick(); check_step("t3", 3);
        last_step = 1'b1;
        tick(); check_step("wrap4", 0);
        check_val("wrap4.done", 32'(instr_done), 32'd1);
        check_val("wrap4.cnt", 32'(instr_count), 32'd1);
        last_step = 1'b0;
        tick(); check_step("after4", 1);
        check_val("after4.done", 32'(instr_done), 32'd0);

        // Stall: T2 held for 4 visible cycles
        tick(); check_step("st.t2", 2);
        wait_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_step("st.hold", 2);
        end
        wait_req = 1'b0;
        tick(); check_step("st.t3", 3);
        check_val("st.cnt", 32'(instr_count), 32'd1);
        last_step = 1'b1;
        tick(); check_step("st.end", 0);
        check_val("st.endcnt", 32'(instr_count), 32'd2);
        last_step = 1'b0;

        // Stop at T1 completes the instruction, then HALT
        tick(); check_step("sp.t1", 1);
        stop = 1'b1;
        tick(); check_step("sp.t2", 2);
        stop = 1'b0;
        tick(); check_step("sp.t3", 3);
        last_step = 1'b1;
        tick(); check_halt("sp.halt");
        check_val("sp.done", 32'(instr_done), 32'd1);
        check_val("sp.cnt", 32'(instr_count), 32'd3);
        last_step = 1'b0;
        tick(); check_halt("sp.idle");
        check_val("sp.idledone", 32'(instr_done), 32'd0);
        start = 1'b1;
        tick(); check_step("sp.start", 0);
        start = 1'b0;

        // wait_req with last_step: stall wins
        last_step = 1'b1;
        wait_req  = 1'b1;
        tick(); check_step("wl.hold", 0);
        check_val("wl.holdcnt", 32'(instr_count), 32'd3);
        check_val("wl.holddone", 32'(instr_done), 32'd0);
        wait_req = 1'b0;
        tick(); check_step("wl.go", 0);
        check_val("wl.gocnt", 32'(instr_count), 32'd4);
        check_val("wl.godone", 32'(instr_done), 32'd1);
        last_step = 1'b0;

        // Single-step: advance only on step_go pulses
        step_mode = 1'b1;
        for (int p = 1; p <= 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                tick(); check_step("ss.hold", p - 1);
            end
            step_go = 1'b1;
            tick(); check_step("ss.pulse", p);
            step_go = 1'b0;
        end
        step_mode = 1'b0;

        // No last_step: forced wrap after T7 with sticky error
        for (int i = 3; i < MAX_STEPS; i++) begin
            tick(); check_step("fw.step", i);
        end
        check_val("fw.err0", 32'(step_err), 32'd0);
        tick(); check_step("fw.wrap", 0);
        check_val("fw.cnt", 32'(instr_count), 32'd5);
        check_val("fw.err1", 32'(step_err), 32'd1);
        tick(); check_step("fw.t1", 1);
        check_val("fw.sticky", 32'(step_err), 32'd1);

        // Stop on the final edge halts immediately; stop+start in HALT: start wins
        stop      = 1'b1;
        last_step = 1'b1;
        tick(); check_halt("ss2.halt");
        check_val("ss2.cnt", 32'(instr_count), 32'd6);
        start = 1'b1;
        tick(); check_step("ss2.start", 0);
        stop  = 1'b0;
        start = 1'b0;
        tick(); check_step("ss2.norun", 0);
        check_val("ss2.cnt7", 32'(instr_count), 32'd7);

        // Counter wraps modulo 16
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        check_val("cw.cnt", 32'(instr_count), 32'd0);
        check_step("cw.run", 0);

        // Asynchronous reset mid-T2
        last_step = 1'b0;
        tick(); check_step("ar.t1", 1);
        tick(); check_step("ar.t2", 2);
        #2 reset = 1'b0;
        #1;
        check_halt("ar");
        check_val("ar.cnt", 32'(instr_count), 32'd0);
        check_val("ar.done", 32'(instr_done), 32'd0);
        check_val("ar.err", 32'(step_err), 32'd0);
        #3 reset = 1'b1;
        tick(); check_step("ar.init", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
